demux1x2_buf: RTL and testbench

- 1-to-2 demultiplexer; the inverse of the team's 2x1 mux.
- One valid/ready input stream is steered by a select bit to one of two output channels.
- Each output channel is buffered by its own FIFO, so a stalled consumer does not block traffic already queued for the other channel.
- Sits between a shared producer and two independent consumers.

---
 rtl/demux1x2_buf.sv | 200 ++++++++++++++++++++
 tb/tb_demux1x2_buf.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_buf.sv
// demux1x2_buf: 1-to-2 valid/ready demultiplexer; each output channel is buffered by its own FIFO.
// Optional per-channel popped-word counters are built when DEMUX1X2_CNT_EN is defined.

module demux1x2_buf_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_rdy,
  output logic              full,
  output logic              rd_vld,
  output logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  lvl
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;

  // Status flags; a full FIFO refuses pushes even while it is being popped.
  always_comb begin
    full   = (lvl_q == LVL_W'(DEPTH));
    rd_vld = (lvl_q != {LVL_W{1'b0}});
    pop    = rd_vld && rd_rdy;
    lvl    = lvl_q;
  end

  // Head word, forced to zero while empty.
  always_comb begin
    if (rd_vld) begin
      rd_data = mem_q[rd_ptr_q];
    end else begin
      rd_data = {DATA_W{1'b0}};
    end
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lvl_d    = lvl_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + LVL_W'(1);
      2'b01:   lvl_d = lvl_q - LVL_W'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // State registers; reset discards any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      lvl_q    <= {LVL_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lvl_q    <= lvl_d;
    end
  end

endmodule

module demux1x2_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_vld,
  input  logic                       enb,
  output logic                       in_rdy,
  output logic [DATA_W-1:0]          out1_data,
  output logic                       out1_vld,
  input  logic                       out1_rdy,
  output logic [DATA_W-1:0]          out2_data,
  output logic                       out2_vld,
  input  logic                       out2_rdy,
  output logic [$clog2(DEPTH):0]     lvl1,
  output logic [$clog2(DEPTH):0]     lvl2,
  output logic [CNT_W-1:0]           cnt1,
  output logic [CNT_W-1:0]           cnt2
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic full1_s, full2_s;
  logic push1_s, push2_s;
  logic pop1_s, pop2_s;

  // Route select: enb=1 steers to channel 1, enb=0 to channel 2.
  always_comb begin
    if (enb) begin
      in_rdy = !full1_s;
    end else begin
      in_rdy = !full2_s;
    end
    push1_s = in_vld && in_rdy && enb;
    push2_s = in_vld && in_rdy && !enb;
  end

  demux1x2_buf_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .push    (push1_s),
    .wr_data (in_data),
    .rd_rdy  (out1_rdy),
    .full    (full1_s),
    .rd_vld  (out1_vld),
    .pop     (pop1_s),
    .rd_data (out1_data),
    .lvl     (lvl1)
  );

  demux1x2_buf_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo2 (
    .clk     (clk),
    .rst     (rst),
    .push    (push2_s),
    .wr_data (in_data),
    .rd_rdy  (out2_rdy),
    .full    (full2_s),
    .rd_vld  (out2_vld),
    .pop     (pop2_s),
    .rd_data (out2_data),
    .lvl     (lvl2)
  );

`ifdef DEMUX1X2_CNT_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  // Popped-word counters, wrapping naturally at 2^CNT_W.
  always_comb begin
    if (pop1_s) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end else begin
      cnt1_d = cnt1_q;
    end
    if (pop2_s) begin
      cnt2_d = cnt2_q + CNT_W'(1);
    end else begin
      cnt2_d = cnt2_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1_q <= {CNT_W{1'b0}};
      cnt2_q <= {CNT_W{1'b0}};
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`else
  logic unused_pop_s;
  assign unused_pop_s = pop1_s ^ pop2_s;
  assign cnt1 = {CNT_W{1'b0}};
  assign cnt2 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_demux1x2_buf.sv
// Directed self-checking bench for demux1x2_buf (DATA_W=8, DEPTH=4, CNT_W=16).
// Counter expectations follow DEMUX1X2_CNT_EN when it is defined for the build.

module tb_demux1x2_buf;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        enb;
  logic        in_rdy;
  logic [7:0]  out1_data;
  logic        out1_vld;
  logic        out1_rdy;
  logic [7:0]  out2_data;
  logic        out2_vld;
  logic        out2_rdy;
  logic [2:0]  lvl1;
  logic [2:0]  lvl2;
  logic [15:0] cnt1;
  logic [15:0] cnt2;

  int checks;
  int errors;
  int exp_cnt1;
  int exp_cnt2;

  demux1x2_buf #(.DATA_W(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .enb       (enb),
    .in_rdy    (in_rdy),
    .out1_data (out1_data),
    .out1_vld  (out1_vld),
    .out1_rdy  (out1_rdy),
    .out2_data (out2_data),
    .out2_vld  (out2_vld),
    .out2_rdy  (out2_rdy),
    .lvl1      (lvl1),
    .lvl2      (lvl2),
    .cnt1      (cnt1),
    .cnt2      (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef DEMUX1X2_CNT_EN
    chk({tag, "_cnt1"}, 32'(cnt1), 32'(exp_cnt1));
    chk({tag, "_cnt2"}, 32'(cnt2), 32'(exp_cnt2));
`else
    chk({tag, "_cnt1"}, 32'(cnt1), 32'd0);
    chk({tag, "_cnt2"}, 32'(cnt2), 32'd0);
`endif
  endtask

  initial begin
    checks = 0; errors = 0; exp_cnt1 = 0; exp_cnt2 = 0;
    rst = 1'b1; in_data = 8'h00; in_vld = 1'b0; enb = 1'b0;
    out1_rdy = 1'b0; out2_rdy = 1'b0;

    // Reset then idle
    tick(); tick();
    chk("rst_lvl1", 32'(lvl1), 32'd0);
    chk("rst_lvl2", 32'(lvl2), 32'd0);
    chk("rst_vld1", 32'(out1_vld), 32'd0);
    chk("rst_vld2", 32'(out2_vld), 32'd0);
    chk("rst_data1", 32'(out1_data), 32'd0);
    chk("rst_data2", 32'(out2_data), 32'd0);
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk_cnt("rst");
    rst = 1'b0;

    // enb toggling with no valid has no effect
    enb = 1'b1; tick(); enb = 1'b0; tick();
    chk("idle_lvl1", 32'(lvl1), 32'd0);
    chk("idle_lvl2", 32'(lvl2), 32'd0);

    // Steering
    in_vld = 1'b1; enb = 1'b1; in_data = 8'hA1;
    tick();
    chk("steer_lat_data1", 32'(out1_data), 32'hA1);
    chk("steer_lat_vld2", 32'(out2_vld), 32'd0);
    enb = 1'b0; in_data = 8'hB2;
    tick();
    in_vld = 1'b0;
    chk("steer_data1", 32'(out1_data), 32'hA1);
    chk("steer_data2", 32'(out2_data), 32'hB2);
    chk("steer_lvl1", 32'(lvl1), 32'd1);
    chk("steer_lvl2", 32'(lvl2), 32'd1);
    out1_rdy = 1'b1; out2_rdy = 1'b1;
    tick();
    exp_cnt1 += 1; exp_cnt2 += 1;
    out1_rdy = 1'b0; out2_rdy = 1'b0;
    chk("drain_lvl1", 32'(lvl1), 32'd0);
    chk("drain_data1", 32'(out1_data), 32'd0);
    chk("drain_vld2", 32'(out2_vld), 32'd0);
    chk_cnt("steer");

    // Fill channel 1
    in_vld = 1'b1; enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h10 + i);
      tick();
    end
    in_data = 8'hEE;
    #1;
    chk("full_lvl1", 32'(lvl1), 32'd4);
    chk("full_in_rdy_enb1", 32'(in_rdy), 32'd0);
    enb = 1'b0; in_vld = 1'b0;
    #1;
    chk("full_in_rdy_enb0", 32'(in_rdy), 32'd1);
    enb = 1'b1; in_vld = 1'b1;
    tick();
    chk("full_reject_lvl1", 32'(lvl1), 32'd4);

    // Full with a pop: still not ready, then drain in order
    out1_rdy = 1'b1;
    #1;
    chk("full_pop_in_rdy", 32'(in_rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("order1_data", 32'(out1_data), 32'(8'h10 + i));
      tick();
      in_vld = 1'b0;
      chk("order1_lvl", 32'(lvl1), 32'(3 - i));
    end
    exp_cnt1 += 4;
    out1_rdy = 1'b0;
    chk("order1_empty_data", 32'(out1_data), 32'd0);
    chk("order1_empty_vld", 32'(out1_vld), 32'd0);

    // Stream 20 words through channel 2 with continuous pops
    out2_rdy = 1'b1; enb = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
      chk("stream_data2", 32'(out2_data), 32'(8'h40 + i));
      chk("stream_lvl2", 32'(lvl2), 32'd1);
    end
    in_vld = 1'b0;
    tick();
    exp_cnt2 += 20;
    out2_rdy = 1'b0;
    chk("stream_end_lvl2", 32'(lvl2), 32'd0);
    chk("stream_end_lvl1", 32'(lvl1), 32'd0);
    chk_cnt("stream");

    // Reset mid-operation
    in_vld = 1'b1; enb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h61 + i);
      tick();
    end
    enb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = 8'(8'h71 + i);
      tick();
    end
    chk("pre_rst_lvl1", 32'(lvl1), 32'd3);
    chk("pre_rst_lvl2", 32'(lvl2), 32'd2);
    rst = 1'b1; enb = 1'b1; in_data = 8'h99; out1_rdy = 1'b1;
    tick();
    rst = 1'b0; in_vld = 1'b0; out1_rdy = 1'b0;
    exp_cnt1 = 0; exp_cnt2 = 0;
    chk("mid_rst_lvl1", 32'(lvl1), 32'd0);
    chk("mid_rst_lvl2", 32'(lvl2), 32'd0);
    chk("mid_rst_vld1", 32'(out1_vld), 32'd0);
    chk("mid_rst_vld2", 32'(out2_vld), 32'd0);
    chk("mid_rst_data1", 32'(out1_data), 32'd0);
    chk_cnt("mid_rst");
    tick();
    chk("post_rst_vld1", 32'(out1_vld), 32'd0);
    chk("post_rst_vld2", 32'(out2_vld), 32'd0);

    // Counters: 3 pops on ch1, 5 on ch2
    out1_rdy = 1'b1; out2_rdy = 1'b1; in_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      enb = (i < 3) ? 1'b1 : 1'b0;
      in_data = 8'(8'h80 + i);
      tick();
      if (i < 3) begin
        chk("cnt_data1", 32'(out1_data), 32'(8'h80 + i));
      end else begin
        chk("cnt_data2", 32'(out2_data), 32'(8'h80 + i));
      end
    end
    in_vld = 1'b0;
    tick(); tick();
    exp_cnt1 += 3; exp_cnt2 += 5;
    chk_cnt("final");
    chk("final_lvl1", 32'(lvl1), 32'd0);
    chk("final_lvl2", 32'(lvl2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
